// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
package fetch_stage_pkg;

    typedef enum logic {
        SReq  = 1'b0,
        SWait = 1'b1
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NopIns   = 32'h0000_0013;
    localparam logic [31:0] PcStep   = 32'd4;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory, redirect input and IF/ID output toward decode.
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;

    // Fetch stage side.
    modport master (
        output imem_req, imem_addr, ins_valid, ins, ins_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, ins_ready
    );

    // Memory, branch unit and decode side.
    modport slave (
        input  imem_req, imem_addr, ins_valid, ins, ins_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, ins_ready
    );

endinterface

// File: rtl/fetch_stage_buf.sv
// One-entry IF/ID buffer: holds a fetched word and its PC until decode takes it.
module fetch_stage_buf
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INS = NopIns
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        ready_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] ins_o,
    output logic [31:0] pc_o
);

    logic        valid_q, valid_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] pc_q, pc_d;

    // Flush beats load beats consume; an empty buffer always shows NOP_INS.
    always_comb begin
        valid_d = valid_q;
        ins_d   = ins_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ins_d   = NOP_INS;
        end else if (load_i) begin
            valid_d = 1'b1;
            ins_d   = data_i;
            pc_d    = pc_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            ins_d   = NOP_INS;
        end
    end

    // Buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ins_q   <= NOP_INS;
            pc_q    <= ZeroWord;
        end else begin
            valid_q <= valid_d;
            ins_q   <= ins_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign ins_o   = ins_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding imem request, stale-response dropping.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = NopIns
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;

    logic        req;
    logic        resp;
    logic        load;
    logic        buf_valid;
    logic [31:0] buf_ins;
    logic [31:0] buf_pc;

    // Request only when the buffer will be free by the time the word returns.
    always_comb begin
        req = 1'b0;
        if (!rst && state_q == SReq) begin
            req = !buf_valid || bus.ins_ready;
        end
        resp = (state_q == SWait) && bus.imem_rvalid;
        load = resp && !drop_q && !bus.redirect_valid;
    end

    // Next state, PC and drop flag; redirect overrides everything else.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        if (bus.redirect_valid) begin
            pc_d = align_word(bus.redirect_pc);
            unique case (state_q)
                SReq: begin
                    // A request granted now targets the old PC, so its data is stale.
                    if (req && bus.imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = SWait;
                    end
                end
                SWait: begin
                    if (bus.imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = SReq;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                default: state_d = SReq;
            endcase
        end else begin
            unique case (state_q)
                SReq: begin
                    if (req && bus.imem_gnt) begin
                        state_d = SWait;
                    end
                end
                SWait: begin
                    if (bus.imem_rvalid) begin
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            pc_d = pc_q + PcStep;
                        end
                        state_d = SReq;
                    end
                end
                default: state_d = SReq;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SReq;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    fetch_stage_buf #(
        .NOP_INS (NOP_INS)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .flush_i (bus.redirect_valid),
        .ready_i (bus.ins_ready),
        .data_i  (bus.imem_rdata),
        .pc_i    (pc_q),
        .valid_o (buf_valid),
        .ins_o   (buf_ins),
        .pc_o    (buf_pc)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.ins_valid = buf_valid;
    assign bus.ins       = buf_ins;
    assign bus.ins_pc    = buf_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed per-cycle vectors for fetch_stage plus a PC wrap sequence on a second instance.
module tb_fetch_stage;

    localparam logic [31:0] N = 32'h0000_0013;

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ins;
        logic [31:0] e_ipc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INS  (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFFC),
        .NOP_INS  (N)
    ) dut_wrap (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdr, input logic [31:0] rp, input logic rdy,
                       input logic q, input logic [31:0] a, input logic iv,
                       input logic [31:0] ins, input logic [31:0] ipc);
        vec_t v;
        v.rst = r; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.redir = rdr; v.rpc = rp;
        v.ready = rdy; v.e_req = q; v.e_addr = a; v.e_iv = iv; v.e_ins = ins; v.e_ipc = ipc;
        vecs.push_back(v);
    endtask

    initial begin
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        bus.redirect_valid = 0; bus.redirect_pc = 0; bus.ins_ready = 0;
        bus2.imem_gnt = 0; bus2.imem_rvalid = 0; bus2.imem_rdata = 0;
        bus2.redirect_valid = 0; bus2.redirect_pc = 0; bus2.ins_ready = 0;

        //  rst gnt rv rdata         rdr rpc         rdy  req addr         iv ins           ipc
        add(1, 0, 0, 0,             0, 0,          0,   0, 32'h000,     0, N,            0);
        // boot fetch at 0
        add(0, 1, 0, 0,             0, 0,          1,   1, 32'h000,     0, N,            0);
        add(0, 0, 1, 32'h00500093,  0, 0,          1,   0, 32'h000,     0, N,            0);
        // backpressure for 5 cycles
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0,         0, 0,          0,   0, 32'h004,     1, 32'h00500093, 0);
        add(0, 1, 0, 0,             0, 0,          1,   1, 32'h004,     1, 32'h00500093, 0);
        add(0, 0, 1, 32'h00A00113,  0, 0,          0,   0, 32'h004,     0, N,            0);
        // delayed grant at 0x8
        add(0, 0, 0, 0,             0, 0,          1,   1, 32'h008,     1, 32'h00A00113, 4);
        add(0, 0, 0, 0,             0, 0,          1,   1, 32'h008,     0, N,            4);
        add(0, 0, 0, 0,             0, 0,          1,   1, 32'h008,     0, N,            4);
        add(0, 1, 0, 0,             0, 0,          1,   1, 32'h008,     0, N,            4);
        add(0, 0, 0, 0,             0, 0,          0,   0, 32'h008,     0, N,            4);
        add(0, 0, 1, 32'h00C00193,  0, 0,          0,   0, 32'h008,     0, N,            4);
        // redirect while waiting, then stale data dropped
        add(0, 1, 0, 0,             0, 0,          1,   1, 32'h00C,     1, 32'h00C00193, 8);
        add(0, 0, 0, 0,             1, 32'h103,    0,   0, 32'h00C,     0, N,            8);
        add(0, 0, 1, 32'hDEADBEEF,  0, 0,          1,   0, 32'h100,     0, N,            8);
        add(0, 1, 0, 0,             0, 0,          1,   1, 32'h100,     0, N,            8);
        add(0, 0, 1, 32'h00100073,  0, 0,          0,   0, 32'h100,     0, N,            8);
        // redirect flushes a full, stalled buffer
        add(0, 0, 0, 0,             1, 32'h200,    0,   0, 32'h104,     1, 32'h00100073, 32'h100);
        add(0, 1, 0, 0,             0, 0,          0,   1, 32'h200,     0, N,            32'h100);
        // redirect together with rvalid
        add(0, 0, 1, 32'h11111111,  1, 32'h302,    0,   0, 32'h200,     0, N,            32'h100);
        add(0, 1, 0, 0,             0, 0,          1,   1, 32'h300,     0, N,            32'h100);
        add(0, 0, 1, 32'h22222222,  0, 0,          0,   0, 32'h300,     0, N,            32'h100);
        // redirect on a grant, then back-to-back redirect in wait
        add(0, 1, 0, 0,             1, 32'h400,    1,   1, 32'h304,     1, 32'h22222222, 32'h300);
        add(0, 0, 0, 0,             1, 32'h500,    0,   0, 32'h400,     0, N,            32'h300);
        add(0, 0, 1, 32'h33333333,  0, 0,          0,   0, 32'h500,     0, N,            32'h300);
        add(0, 0, 0, 0,             0, 0,          1,   1, 32'h500,     0, N,            32'h300);
        // reset mid-stream masks the request
        add(1, 1, 0, 0,             0, 0,          1,   0, 32'h500,     0, N,            32'h300);
        add(0, 0, 0, 0,             0, 0,          1,   1, 32'h000,     0, N,            0);

        repeat (2) @(posedge clk);
        foreach (vecs[k]) begin
            @(negedge clk);
            rst                = vecs[k].rst;
            bus.imem_gnt       = vecs[k].gnt;
            bus.imem_rvalid    = vecs[k].rvalid;
            bus.imem_rdata     = vecs[k].rdata;
            bus.redirect_valid = vecs[k].redir;
            bus.redirect_pc    = vecs[k].rpc;
            bus.ins_ready      = vecs[k].ready;
            #1;
            chk($sformatf("v%0d req", k), {31'd0, bus.imem_req}, {31'd0, vecs[k].e_req});
            chk($sformatf("v%0d addr", k), bus.imem_addr, vecs[k].e_addr);
            chk($sformatf("v%0d ins_valid", k), {31'd0, bus.ins_valid}, {31'd0, vecs[k].e_iv});
            chk($sformatf("v%0d ins", k), bus.ins, vecs[k].e_ins);
            chk($sformatf("v%0d ins_pc", k), bus.ins_pc, vecs[k].e_ipc);
        end

        // PC wrap on the second instance
        @(negedge clk);
        rst2 = 1'b0;
        bus2.imem_gnt = 1'b1;
        bus2.ins_ready = 1'b1;
        #1;
        chk("wrap first req", {31'd0, bus2.imem_req}, 32'd1);
        chk("wrap first addr", bus2.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        bus2.imem_gnt = 1'b0;
        bus2.imem_rvalid = 1'b1;
        bus2.imem_rdata = 32'h0000_0013;
        #1;
        chk("wrap wait req", {31'd0, bus2.imem_req}, 32'd0);
        @(negedge clk);
        bus2.imem_rvalid = 1'b0;
        #1;
        chk("wrap ins_valid", {31'd0, bus2.ins_valid}, 32'd1);
        chk("wrap ins_pc", bus2.ins_pc, 32'hFFFF_FFFC);
        chk("wrap second req", {31'd0, bus2.imem_req}, 32'd1);
        chk("wrap second addr", bus2.imem_addr, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
